// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
//   Shared definitions for the serial link bring-up sequencer:
//     - bringup_state_e : sequencer FSM states
//     - Ctrl*           : CTRL register values written during bring-up, in order
//     - slink_apb_req_t : default APB request struct  (paddr, pprot, psel,
//                         penable, pwrite, pwdata, pstrb)
//     - slink_apb_rsp_t : default APB response struct (pready, prdata, pslverr)
//     - ctrl_step_data  : maps the 2-bit write step onto its CTRL value
// -----------------------------------------------------------------------------
package serial_link_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_SETUP,
      WR_ACCESS,
      SETTLE,
      RD_SETUP,
      RD_ACCESS,
      DONE,
      ERROR
   } bringup_state_e;

   // CTRL sequence: release reset, pulse reset, enable clock, drop isolation.
   localparam logic [31:0] CtrlRstDeassert = 32'h0000_0300;
   localparam logic [31:0] CtrlRstAssert   = 32'h0000_0302;
   localparam logic [31:0] CtrlClkEn       = 32'h0000_0303;
   localparam logic [31:0] CtrlDeisolate   = 32'h0000_0003;

   typedef struct packed {
      logic [31:0] paddr;
      logic [2:0]  pprot;
      logic        psel;
      logic        penable;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
   } slink_apb_req_t;

   typedef struct packed {
      logic        pready;
      logic [31:0] prdata;
      logic        pslverr;
   } slink_apb_rsp_t;

   function automatic logic [31:0] ctrl_step_data(input logic [1:0] step);
      logic [31:0] data;
      case (step)
         2'd0:    data = CtrlRstDeassert;
         2'd1:    data = CtrlRstAssert;
         2'd2:    data = CtrlClkEn;
         default: data = CtrlDeisolate;
      endcase
      return data;
   endfunction

endpackage

// File: rtl/serial_link_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// serial_link_bringup_ctrl
//   APB master that brings a serial link out of reset and isolation on its own:
//   writes CTRL = 0x300, 0x302, 0x303, waits SettleCycles, writes CTRL = 0x003,
//   then polls ISOLATED until it reads zero (or MaxPolls reads elapse).
//
//   Ports:
//     clk_i      single clock for the sequencer and the APB bus
//     rst_i      synchronous, active-high reset
//     start_i    one-cycle pulse that (re)starts the sequence when not busy
//     busy_o     high while the sequence is running
//     done_o     sticky: link reported de-isolation
//     error_o    sticky: pslverr seen or poll budget exhausted
//     apb_req_o  APB request to the link config port (registered)
//     apb_rsp_i  APB response from the link config port
//
//   Every output is registered and updated together with the state, so each
//   APB transfer takes exactly setup + access (+ slave wait) cycles.
// -----------------------------------------------------------------------------
module serial_link_bringup_ctrl
   import serial_link_pkg::*;
#(
   parameter logic [31:0] CtrlAddr     = 32'h0000_0000,
   parameter logic [31:0] IsolatedAddr = 32'h0000_0004,
   parameter int unsigned SettleCycles = 50,
   parameter int unsigned MaxPolls     = 1024,
   parameter type         apb_req_t    = slink_apb_req_t,
   parameter type         apb_rsp_t    = slink_apb_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     start_i,
   output logic     busy_o,
   output logic     done_o,
   output logic     error_o,
   output apb_req_t apb_req_o,
   input  apb_rsp_t apb_rsp_i
);

   localparam int SettleW = $clog2(SettleCycles + 1);
   localparam int PollW   = $clog2(MaxPolls + 1);

   bringup_state_e     state;
   logic [1:0]         step;
   logic [SettleW-1:0] settle_cnt;
   logic [PollW-1:0]   poll_cnt;
   logic [PollW-1:0]   poll_nxt;

   // Poll count never exceeds MaxPolls-1 before this increment, so no wrap.
   assign poll_nxt = poll_cnt + 1'b1;

   // Setup-phase request for a CTRL write.
   function automatic apb_req_t wr_setup_req(input logic [31:0] data);
      apb_req_t r;
      r         = '0;
      r.psel    = 1'b1;
      r.pwrite  = 1'b1;
      r.paddr   = CtrlAddr;
      r.pwdata  = data;
      r.pstrb   = 4'hF;
      return r;
   endfunction

   // Setup-phase request for an ISOLATED read.
   function automatic apb_req_t rd_setup_req();
      apb_req_t r;
      r       = '0;
      r.psel  = 1'b1;
      r.paddr = IsolatedAddr;
      return r;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         step       <= 2'd0;
         settle_cnt <= '0;
         poll_cnt   <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         error_o    <= 1'b0;
         apb_req_o  <= '0;
      end else begin
         case (state)
            // Terminal and idle states share the restart path.
            IDLE, DONE, ERROR: begin
               if (start_i) begin
                  state     <= WR_SETUP;
                  step      <= 2'd0;
                  poll_cnt  <= '0;
                  busy_o    <= 1'b1;
                  done_o    <= 1'b0;
                  error_o   <= 1'b0;
                  apb_req_o <= wr_setup_req(ctrl_step_data(2'd0));
               end
            end

            WR_SETUP: begin
               state             <= WR_ACCESS;
               apb_req_o.penable <= 1'b1;
            end

            WR_ACCESS: begin
               if (apb_rsp_i.pready) begin
                  if (apb_rsp_i.pslverr) begin
                     state     <= ERROR;
                     busy_o    <= 1'b0;
                     error_o   <= 1'b1;
                     apb_req_o <= '0;
                  end else begin
                     case (step)
                        2'd0, 2'd1: begin
                           state     <= WR_SETUP;
                           step      <= step + 2'd1;
                           apb_req_o <= wr_setup_req(ctrl_step_data(step + 2'd1));
                        end
                        2'd2: begin
                           state      <= SETTLE;
                           settle_cnt <= '0;
                           apb_req_o  <= '0;
                        end
                        default: begin
                           state     <= RD_SETUP;
                           apb_req_o <= rd_setup_req();
                        end
                     endcase
                  end
               end
            end

            // Bus idle while the link clock settles; exit after SettleCycles.
            SETTLE: begin
               if (settle_cnt == SettleW'(SettleCycles - 1)) begin
                  state     <= WR_SETUP;
                  step      <= 2'd3;
                  apb_req_o <= wr_setup_req(ctrl_step_data(2'd3));
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            RD_SETUP: begin
               state             <= RD_ACCESS;
               apb_req_o.penable <= 1'b1;
            end

            RD_ACCESS: begin
               if (apb_rsp_i.pready) begin
                  if (apb_rsp_i.pslverr) begin
                     state     <= ERROR;
                     busy_o    <= 1'b0;
                     error_o   <= 1'b1;
                     apb_req_o <= '0;
                  end else if (apb_rsp_i.prdata == 32'h0) begin
                     state     <= DONE;
                     busy_o    <= 1'b0;
                     done_o    <= 1'b1;
                     apb_req_o <= '0;
                  end else begin
                     poll_cnt <= poll_nxt;
                     if (poll_nxt == PollW'(MaxPolls)) begin
                        state     <= ERROR;
                        busy_o    <= 1'b0;
                        error_o   <= 1'b1;
                        apb_req_o <= '0;
                     end else begin
                        // Back-to-back re-poll: keep psel, restart setup phase.
                        state             <= RD_SETUP;
                        apb_req_o.penable <= 1'b0;
                     end
                  end
               end
            end

            default: begin
               state     <= IDLE;
               busy_o    <= 1'b0;
               apb_req_o <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_link_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_link_bringup_ctrl
//   Drives the sequencer against a configurable APB slave (wait states, read
//   data list, pslverr injection) and compares the logged transfers, end cycle
//   and status flags with a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_serial_link_bringup_ctrl;
   import serial_link_pkg::*;

   localparam int          Settle = 50;
   localparam int          MaxP   = 4;
   localparam logic [31:0] CAddr  = 32'h0000_0000;
   localparam logic [31:0] IAddr  = 32'h0000_0004;

   logic           clk_i = 1'b0;
   logic           rst_i, start_i, busy_o, done_o, error_o;
   slink_apb_req_t apb_req_o;
   slink_apb_rsp_t apb_rsp_i;

   int checks   = 0;
   int failures = 0;

   serial_link_bringup_ctrl #(
      .CtrlAddr(CAddr), .IsolatedAddr(IAddr),
      .SettleCycles(Settle), .MaxPolls(MaxP),
      .apb_req_t(slink_apb_req_t), .apb_rsp_t(slink_apb_rsp_t)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .apb_req_o(apb_req_o), .apb_rsp_i(apb_rsp_i)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- slave ----------------
   typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} txn_t;

   int          wait_states = 0;
   logic [31:0] rd_arr [16];
   int          rd_len  = 0;
   logic [31:0] rd_def  = 32'h0;
   int          rd_base = 0;
   int          err_on  = -1;
   int          wcnt = 0, xfer_idx = 0, rd_idx = 0, stab_err = 0, rd_off;
   logic [31:0] cap_a = '0, cap_d = '0;
   logic        cap_w = 1'b0;
   txn_t        log_q [$];
   txn_t        exp_q [$];

   assign rd_off            = rd_idx - rd_base;
   assign apb_rsp_i.pready  = apb_req_o.psel && apb_req_o.penable && (wcnt >= wait_states);
   assign apb_rsp_i.pslverr = apb_rsp_i.pready && (xfer_idx == err_on);
   assign apb_rsp_i.prdata  = (rd_off < rd_len) ? rd_arr[rd_off[3:0]] : rd_def;

   always @(posedge clk_i) begin
      if (rst_i) begin
         wcnt <= 0; xfer_idx <= 0; rd_idx <= 0;
      end else if (apb_req_o.psel && apb_req_o.penable) begin
         if (apb_req_o.paddr !== cap_a || apb_req_o.pwdata !== cap_d || apb_req_o.pwrite !== cap_w)
            stab_err <= stab_err + 1;
         if (apb_rsp_i.pready) begin
            log_q.push_back(txn_t'({apb_req_o.pwrite, apb_req_o.paddr,
                                    apb_req_o.pwrite ? apb_req_o.pwdata : apb_rsp_i.prdata}));
            xfer_idx <= xfer_idx + 1;
            wcnt     <= 0;
            if (!apb_req_o.pwrite) rd_idx <= rd_idx + 1;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else if (apb_req_o.psel) begin
         cap_a <= apb_req_o.paddr; cap_d <= apb_req_o.pwdata; cap_w <= apb_req_o.pwrite;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: expected transfer list, outcome and first cycle (counted
   // from the start_i edge) on which busy_o is low.
   bit exp_done, exp_err;
   int exp_cyc;
   task automatic model(input int w, input int err_rel);
      logic [31:0] wd [4];
      logic [31:0] v;
      int n;
      bit stop;
      wd = '{32'h300, 32'h302, 32'h303, 32'h003};
      exp_q.delete();
      n = 0; exp_done = 0; exp_err = 0; stop = 0;
      for (int i = 0; i < 4 && !stop; i++) begin
         exp_q.push_back(txn_t'({1'b1, CAddr, wd[i]}));
         n++;
         if (n - 1 == err_rel) begin exp_err = 1; stop = 1; end
      end
      for (int p = 0; !stop; p++) begin
         v = (p < rd_len) ? rd_arr[p] : rd_def;
         exp_q.push_back(txn_t'({1'b0, IAddr, v}));
         n++;
         if (n - 1 == err_rel)  begin exp_err = 1;  stop = 1; end
         else if (v == 32'h0)   begin exp_done = 1; stop = 1; end
         else if (p + 1 == MaxP) begin exp_err = 1; stop = 1; end
      end
      exp_cyc = 1 + n * (2 + w) + ((n > 3) ? Settle : 0);
   endtask

   task automatic run(input string tag, input int w, input int err_rel, input bit poke);
      int base, cyc, stab0, nlog;
      bit fin;
      wait_states = w;
      rd_base     = rd_idx;
      err_on      = (err_rel < 0) ? -1 : xfer_idx + err_rel;
      base        = log_q.size();
      stab0       = stab_err;
      model(w, err_rel);
      start_i = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      start_i = 1'b0;
      chk({tag, "/cycle1"}, {busy_o, done_o, error_o}, 3'b100);
      cyc = 1; fin = 0;
      while (!fin && cyc < 3000) begin
         start_i = poke && (cyc == 4 || cyc == 30);
         @(posedge clk_i); @(negedge clk_i);
         cyc++;
         if (!busy_o) fin = 1;
      end
      start_i = 1'b0;
      chk({tag, "/end_cycle"}, cyc, exp_cyc);
      chk({tag, "/flags"}, {busy_o, done_o, error_o}, {1'b0, exp_done, exp_err});
      chk({tag, "/bus_idle"}, {apb_req_o.psel, apb_req_o.penable}, 2'b00);
      nlog = log_q.size() - base;
      chk({tag, "/n_xfers"}, nlog, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < nlog; i++)
         chk($sformatf("%s/xfer%0d", tag, i), log_q[base + i], exp_q[i]);
      chk({tag, "/stable"}, stab_err - stab0, 0);
      repeat (3) @(negedge clk_i);
      chk({tag, "/sticky"}, {busy_o, done_o, error_o, apb_req_o.psel}, {1'b0, exp_done, exp_err, 1'b0});
      chk({tag, "/no_more_xfers"}, log_q.size() - base, exp_q.size());
   endtask

   task automatic reset_test(input string tag, input bit in_read);
      int cyc;
      bit hit;
      wait_states = 3; rd_base = rd_idx; rd_len = 0; rd_def = 32'h5; err_on = -1;
      start_i = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      start_i = 1'b0;
      hit = 0; cyc = 0;
      while (!hit && cyc < 500) begin
         if (in_read) hit = apb_req_o.psel && apb_req_o.penable && !apb_req_o.pwrite;
         else         hit = busy_o && !apb_req_o.psel;
         if (!hit) begin @(posedge clk_i); @(negedge clk_i); cyc++; end
      end
      chk({tag, "/reached"}, hit, 1'b1);
      rst_i = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      chk({tag, "/flags"}, {busy_o, done_o, error_o}, 3'b000);
      chk({tag, "/req"}, apb_req_o, '0);
      rst_i = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
      chk({tag, "/stays_idle"}, {busy_o, done_o, error_o, apb_req_o.psel}, 4'b0000);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int w, n, e;
      rst_i = 1'b1; start_i = 1'b0;
      for (int i = 0; i < 16; i++) rd_arr[i] = 32'h0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("reset_flags", {busy_o, done_o, error_o}, 3'b000);
      chk("reset_req", apb_req_o, '0);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("idle_without_start", {busy_o, done_o, error_o, apb_req_o.psel}, 4'b0000);

      rd_len = 1; rd_arr[0] = 32'h0; rd_def = 32'h0;
      run("zero_wait", 0, -1, 1'b0);
      chk("zero_wait_done_at_61", exp_cyc, 61);
      run("wait3", 3, -1, 1'b0);

      rd_len = 4;
      rd_arr[0] = 32'h3; rd_arr[1] = 32'h3; rd_arr[2] = 32'h1; rd_arr[3] = 32'h0;
      run("polls_3310", 0, -1, 1'b1);

      rd_len = 0; rd_def = 32'h3;
      run("poll_timeout", 0, -1, 1'b0);

      rd_len = 1; rd_arr[0] = 32'h0; rd_def = 32'h0;
      run("slverr_302", 0, 1, 1'b0);
      run("restart", 0, -1, 1'b0);

      reset_test("rst_settle", 1'b0);
      reset_test("rst_rd_access", 1'b1);

      for (int k = 0; k < 8; k++) begin
         w = $urandom_range(0, 3);
         n = $urandom_range(0, 5);
         rd_len = n;
         for (int j = 0; j < n; j++)
            rd_arr[j] = (j == n - 1 && $urandom_range(0, 1) == 1) ? 32'h0 : 32'($urandom_range(1, 255));
         rd_def = ($urandom_range(0, 1) == 1) ? 32'h0 : 32'h7;
         e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
         run($sformatf("rand%0d", k), w, e, $urandom_range(0, 1) == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
